// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA timing receiver: counter width, saturation
// value, lock-FSM state encoding and the 640x480 reference totals.
package vga_pkg;

  localparam int unsigned CNT_W = 10;
  localparam logic [CNT_W-1:0] CNT_MAX = 10'd1023;

  localparam int unsigned H_TOTAL = 800;
  localparam int unsigned V_TOTAL = 525;

  typedef logic [1:0] state_t;

  localparam state_t StIdle   = 2'd0;
  localparam state_t StSearch = 2'd1;
  localparam state_t StTrack  = 2'd2;
  localparam state_t StLock   = 2'd3;

  // Increment that sticks at CNT_MAX instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? CNT_MAX : v + 10'd1;
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer plus leading-edge detector for one sync input; flops only advance
// on enabled cycles and reset to the deasserted level so release cannot fake an edge.
module sync_edge_detect #(
  parameter bit POL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic async_i,
  output logic edge_o
);

  logic sync1_q, sync2_q, prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= ~POL;
      sync2_q <= ~POL;
      prev_q  <= ~POL;
    end else if (en_i) begin
      sync1_q <= async_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign edge_o = en_i & (sync2_q == POL) & (prev_q != POL);

endmodule

// File: rtl/vga_timing_rx.sv
// Recovers pixel/line position from HSYNC/VSYNC, measures line and frame totals and runs a
// lock FSM that declares the timing stable after LOCK_FRAMES consecutive matching frames.
module vga_timing_rx
  import vga_pkg::*;
#(
  parameter bit          HSYNC_POL   = 1'b0,
  parameter bit          VSYNC_POL   = 1'b0,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             pix_en_i,
  input  logic             hsync_i,
  input  logic             vsync_i,
  output logic [CNT_W-1:0] hcnt_o,
  output logic [CNT_W-1:0] vcnt_o,
  output logic [CNT_W-1:0] line_total_o,
  output logic [CNT_W-1:0] frame_total_o,
  output logic             locked_o,
  output logic             frame_start_o,
  output logic             err_o
);

  localparam logic [3:0] LockCnt = LOCK_FRAMES[3:0];

  logic h_edge, v_edge;

  sync_edge_detect #(
    .POL(HSYNC_POL)
  ) u_hsync_edge (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .en_i   (pix_en_i),
    .async_i(hsync_i),
    .edge_o (h_edge)
  );

  sync_edge_detect #(
    .POL(VSYNC_POL)
  ) u_vsync_edge (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .en_i   (pix_en_i),
    .async_i(vsync_i),
    .edge_o (v_edge)
  );

  logic [CNT_W-1:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic [CNT_W-1:0] line_total_q, line_total_d, frame_total_q, frame_total_d;
  logic [CNT_W-1:0] line_cap, frame_cap;
  state_t           state_q, state_d;
  logic [3:0]       match_q, match_d, match_inc;
  logic             err_q, err_d, fs_q, fs_d;
  logic             err_ev, line_mismatch, h_sat_hit, v_sat_hit, tracking;

  assign line_cap  = sat_inc(hcnt_q);
  assign frame_cap = sat_inc(vcnt_q);
  assign match_inc = match_q + 4'd1;
  assign tracking  = (state_q == StTrack) || (state_q == StLock);

  // Saturation is flagged only on the step into CNT_MAX, so a stuck counter errors once.
  assign h_sat_hit = pix_en_i & ~h_edge & (hcnt_q == CNT_MAX - 10'd1);
  assign v_sat_hit = h_edge & ~v_edge & (vcnt_q == CNT_MAX - 10'd1);
  assign line_mismatch = h_edge & tracking & (line_cap != line_total_q);

  always_comb begin
    hcnt_d        = hcnt_q;
    vcnt_d        = vcnt_q;
    line_total_d  = line_total_q;
    frame_total_d = frame_total_q;
    if (pix_en_i) begin
      if (h_edge) begin
        hcnt_d       = '0;
        line_total_d = line_cap;
      end else begin
        hcnt_d = sat_inc(hcnt_q);
      end
      // A VSYNC edge takes priority over the line increment of a coincident HSYNC edge.
      if (v_edge) begin
        vcnt_d        = '0;
        frame_total_d = frame_cap;
      end else if (h_edge) begin
        vcnt_d = sat_inc(vcnt_q);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    match_d = match_q;
    err_ev  = 1'b0;
    if (v_edge) begin
      case (state_q)
        StIdle:   state_d = StSearch;
        StSearch: begin
          state_d = StTrack;
          match_d = '0;
        end
        StTrack, StLock: begin
          if (frame_cap != frame_total_q) begin
            err_ev  = 1'b1;
            state_d = StSearch;
            match_d = '0;
          end else if (state_q == StTrack) begin
            match_d = match_inc;
            if (match_inc >= LockCnt) state_d = StLock;
          end
        end
        default:  state_d = StIdle;
      endcase
    end
    if (line_mismatch || h_sat_hit || v_sat_hit) begin
      err_ev  = 1'b1;
      state_d = StSearch;
      match_d = '0;
    end
  end

  // Pulses last one pixel period: they are held, like all other state, on idle cycles.
  assign err_d = pix_en_i ? err_ev : err_q;
  assign fs_d  = pix_en_i ? v_edge : fs_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hcnt_q        <= '0;
      vcnt_q        <= '0;
      line_total_q  <= '0;
      frame_total_q <= '0;
      state_q       <= StIdle;
      match_q       <= '0;
      err_q         <= 1'b0;
      fs_q          <= 1'b0;
    end else begin
      hcnt_q        <= hcnt_d;
      vcnt_q        <= vcnt_d;
      line_total_q  <= line_total_d;
      frame_total_q <= frame_total_d;
      state_q       <= state_d;
      match_q       <= match_d;
      err_q         <= err_d;
      fs_q          <= fs_d;
    end
  end

  assign hcnt_o        = hcnt_q;
  assign vcnt_o        = vcnt_q;
  assign line_total_o  = line_total_q;
  assign frame_total_o = frame_total_q;
  assign locked_o      = (state_q == StLock);
  assign frame_start_o = fs_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_vga_timing_rx.sv
// Directed bench for vga_timing_rx using a reduced raster (64 px x 10 lines) for lock
// sequencing, plus full-length 800 px lines and 525-line frames for the total captures.
module tb_vga_timing_rx;
  import vga_pkg::*;

  logic       clk = 1'b0, rst_n = 1'b0, pix_en = 1'b0, hsync = 1'b1, vsync = 1'b1;
  logic [9:0] hcnt, vcnt, line_total, frame_total;
  logic       locked, frame_start, err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vga_timing_rx dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .pix_en_i     (pix_en),
    .hsync_i      (hsync),
    .vsync_i      (vsync),
    .hcnt_o       (hcnt),
    .vcnt_o       (vcnt),
    .line_total_o (line_total),
    .frame_total_o(frame_total),
    .locked_o     (locked),
    .frame_start_o(frame_start),
    .err_o        (err)
  );

  // Stimulus generator state
  int line_len, frame_lines, hs_w, vs_w, px, ln, short_ln, gen_frames;
  bit gen_on, half, pe_phase;

  // Monitor state
  int          errs_seen, fs_seen, lock_rises, lock_gen_frames, frozen_bad;
  bit          lock_fs_same, locked_prev, err_lk_prev, err_lk_now;
  logic [42:0] snap;

  function automatic logic [42:0] outs();
    return {hcnt, vcnt, line_total, frame_total, locked, frame_start, err};
  endfunction

  task automatic clear_mon();
    errs_seen = 0; fs_seen = 0; lock_rises = 0; lock_gen_frames = -1; frozen_bad = 0;
    lock_fs_same = 0; err_lk_prev = 0; err_lk_now = 1;
  endtask

  // One clock: drive inputs at negedge, observe 1 ns after the rising edge.
  task automatic tick();
    int eff_len;
    @(negedge clk);
    if (half) begin
      pe_phase = ~pe_phase;
      pix_en   = pe_phase;
    end else begin
      pix_en = 1'b1;
    end
    if (pix_en && gen_on) begin
      hsync = (px < hs_w) ? 1'b0 : 1'b1;
      vsync = (ln < vs_w) ? 1'b0 : 1'b1;
      if (px == 0 && ln == 0) gen_frames++;
      eff_len = (ln == short_ln) ? line_len - 1 : line_len;
      px++;
      if (px >= eff_len) begin
        px = 0;
        if (ln == short_ln) short_ln = -1;
        ln = (ln + 1 >= frame_lines) ? 0 : ln + 1;
      end
    end
    @(posedge clk);
    #1;
    if (pix_en) begin
      if (err === 1'b1) begin
        errs_seen++;
        err_lk_prev = locked_prev;
        err_lk_now  = (locked === 1'b1);
      end
      if (frame_start === 1'b1) fs_seen++;
      if (locked === 1'b1 && !locked_prev) begin
        lock_rises++;
        lock_gen_frames = gen_frames;
        lock_fs_same    = (frame_start === 1'b1);
      end
    end else if (outs() !== snap) begin
      frozen_bad++;
    end
    snap        = outs();
    locked_prev = (locked === 1'b1);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    pix_en = 1'b0; hsync = 1'b1; vsync = 1'b1;
    line_len = 64; frame_lines = 10; hs_w = 8; vs_w = 2;
    px = 0; ln = 0; short_ln = -1; gen_frames = 0;
    gen_on = 1'b1; half = 1'b0; pe_phase = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    clear_mon();
    locked_prev = 1'b0;
    snap = outs();
  endtask

  task automatic test_reset();
    do_reset();
    run(50);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (outs() !== 43'b0) begin errors++; $display("FAIL reset_async_outs: got %h expected 0", outs()); end
    checks++; if (dut.state_q !== StIdle) begin errors++; $display("FAIL reset_state: got %0d expected %0d", dut.state_q, StIdle); end
    do_reset();
    gen_on = 1'b0;
    run(5);
    checks++; if (hcnt !== 10'd5) begin errors++; $display("FAIL reset_hcnt_count: got %0d expected 5", hcnt); end
    checks++; if (vcnt !== 10'd0 || line_total !== 10'd0) begin errors++; $display("FAIL reset_no_edge: vcnt %0d line_total %0d expected 0 0", vcnt, line_total); end
    checks++; if (fs_seen !== 0 || errs_seen !== 0) begin errors++; $display("FAIL reset_no_pulse: fs %0d err %0d expected 0 0", fs_seen, errs_seen); end
  endtask

  task automatic test_lock();
    do_reset();
    run(6 * 640);
    checks++; if (line_total !== 10'd64) begin errors++; $display("FAIL lock_line_total: got %0d expected 64", line_total); end
    checks++; if (frame_total !== 10'd10) begin errors++; $display("FAIL lock_frame_total: got %0d expected 10", frame_total); end
    checks++; if (lock_rises !== 1 || locked !== 1'b1) begin errors++; $display("FAIL lock_rise: rises %0d locked %b expected 1 1", lock_rises, locked); end
    checks++; if (lock_gen_frames !== 4 || !lock_fs_same) begin errors++; $display("FAIL lock_4th_edge: frame %0d fs %b expected 4 1", lock_gen_frames, lock_fs_same); end
    checks++; if (fs_seen !== 6) begin errors++; $display("FAIL lock_fs_count: got %0d expected 6", fs_seen); end
    checks++; if (errs_seen !== 0) begin errors++; $display("FAIL lock_no_err: got %0d expected 0", errs_seen); end
  endtask

  task automatic test_line_800();
    do_reset();
    line_len = H_TOTAL; frame_lines = 1000;
    run(2410);
    checks++; if (line_total !== 10'd800) begin errors++; $display("FAIL l800_line_total: got %0d expected 800", line_total); end
    checks++; if (hcnt !== 10'd7 || vcnt !== 10'd3) begin errors++; $display("FAIL l800_pos: got %0d/%0d expected 7/3", hcnt, vcnt); end
    checks++; if (frame_total !== 10'd1) begin errors++; $display("FAIL l800_frame_total: got %0d expected 1", frame_total); end
  endtask

  task automatic test_simul_edges();
    do_reset();
    line_len = 16; hs_w = 4; frame_lines = V_TOTAL;
    run(8402);
    checks++; if (vcnt !== 10'd524) begin errors++; $display("FAIL simul_pre_vcnt: got %0d expected 524", vcnt); end
    run(1);
    checks++; if (vcnt !== 10'd0 || hcnt !== 10'd0) begin errors++; $display("FAIL simul_pos: got %0d/%0d expected 0/0", hcnt, vcnt); end
    checks++; if (frame_total !== 10'd525 || frame_start !== 1'b1) begin errors++; $display("FAIL simul_frame_total: got %0d fs %b expected 525 1", frame_total, frame_start); end
  endtask

  task automatic test_short_line();
    int base;
    do_reset();
    run(5 * 640);
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL short_pre_locked: got %b expected 1", locked); end
    clear_mon();
    base = gen_frames;
    short_ln = 5;
    run(4 * 640);
    checks++; if (errs_seen !== 1) begin errors++; $display("FAIL short_err_count: got %0d expected 1", errs_seen); end
    checks++; if (!err_lk_prev || err_lk_now) begin errors++; $display("FAIL short_lock_drop: before %b at_err %b expected 1 0", err_lk_prev, err_lk_now); end
    checks++; if (lock_rises !== 1 || lock_gen_frames !== base + 4) begin errors++; $display("FAIL short_relock: rises %0d frame %0d expected 1 %0d", lock_rises, lock_gen_frames, base + 4); end
  endtask

  task automatic test_saturate();
    do_reset();
    gen_on = 1'b0;
    run(1100);
    checks++; if (hcnt !== 10'd1023) begin errors++; $display("FAIL sat_hcnt: got %0d expected 1023", hcnt); end
    checks++; if (errs_seen !== 1) begin errors++; $display("FAIL sat_err_count: got %0d expected 1", errs_seen); end
    checks++; if (dut.state_q !== StSearch) begin errors++; $display("FAIL sat_state: got %0d expected %0d", dut.state_q, StSearch); end
  endtask

  task automatic test_half_rate();
    do_reset();
    half = 1'b1;
    run(2 * 6 * 640);
    checks++; if (line_total !== 10'd64 || frame_total !== 10'd10) begin errors++; $display("FAIL half_totals: got %0d/%0d expected 64/10", line_total, frame_total); end
    checks++; if (fs_seen !== 6) begin errors++; $display("FAIL half_fs_count: got %0d expected 6", fs_seen); end
    checks++; if (lock_rises !== 1 || lock_gen_frames !== 4) begin errors++; $display("FAIL half_lock: rises %0d frame %0d expected 1 4", lock_rises, lock_gen_frames); end
    checks++; if (frozen_bad !== 0) begin errors++; $display("FAIL half_frozen: got %0d changes expected 0", frozen_bad); end
  endtask

  task automatic test_reset_mid_frame();
    int base;
    do_reset();
    run(5 * 640 + 5 * 64 + 20);
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL mid_pre_locked: got %b expected 1", locked); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (outs() !== 43'b0) begin errors++; $display("FAIL mid_async_outs: got %h expected 0", outs()); end
    run(2);
    clear_mon();
    rst_n = 1'b1;
    base = gen_frames;
    run(20);
    checks++; if (fs_seen !== 0 || errs_seen !== 0) begin errors++; $display("FAIL mid_release_pulse: fs %0d err %0d expected 0 0", fs_seen, errs_seen); end
    run(5 * 640);
    checks++; if (lock_rises !== 1 || lock_gen_frames !== base + 4) begin errors++; $display("FAIL mid_relock: rises %0d frame %0d expected 1 %0d", lock_rises, lock_gen_frames, base + 4); end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_line_800();
    test_simul_edges();
    test_short_line();
    test_saturate();
    test_half_rate();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
